// File: rtl/mux_op_sequencer_if.sv
// Command, mux-datapath and result signals of mux_op_sequencer.
// The slave modport is the sequencer side; the master modport is the environment side.
interface mux_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_select;
  logic [3:0] cmd_d0;
  logic [3:0] cmd_d1;
  logic [2:0] mux_select;
  logic [3:0] mux_d0;
  logic [3:0] mux_d1;
  logic [3:0] mux_q_0;
  logic [3:0] mux_q_1;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_select;
  logic [3:0] res_q_0;
  logic [3:0] res_q_1;
  logic       busy;
  logic [7:0] done_count;

  modport master (
    output cmd_valid, cmd_select, cmd_d0, cmd_d1, mux_q_0, mux_q_1, res_ready,
    input  cmd_ready, mux_select, mux_d0, mux_d1, res_valid, res_select, res_q_0, res_q_1,
    input  busy, done_count
  );

  modport slave (
    input  cmd_valid, cmd_select, cmd_d0, cmd_d1, mux_q_0, mux_q_1, res_ready,
    output cmd_ready, mux_select, mux_d0, mux_d1, res_valid, res_select, res_q_0, res_q_1,
    output busy, done_count
  );
endinterface

// File: rtl/mux_op_sequencer.sv
// Queues mux operations, drives each onto the external select/mux datapath for a
// programmable settle time, captures its outputs and offers them on a valid/ready port.
module mux_op_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  mux_op_sequencer_if.slave bus
);
  localparam int unsigned   AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW         = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_CNT   = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StResult} state_e;

  state_e        state_q, state_d;
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ready_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    op_sel_q;
  logic [3:0]    op_d0_q, op_d1_q;
  logic [2:0]    res_sel_q;
  logic [3:0]    res_q0_q, res_q1_q;
  logic [7:0]    done_q;
  logic          push, pop, capture, handshake, empty, full;
  logic [10:0]   head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign head  = mem_q[rd_ptr_q];
  // ready_q keeps cmd_ready low until the first edge after reset release
  assign push  = bus.cmd_valid & ready_q & ~full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == LAST_CNT) begin
          capture = 1'b1;
          state_d = StResult;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResult: begin
        if (bus.res_ready) begin
          handshake = 1'b1;
          // Chain straight into the next op to sustain one result per SETTLE_CYCLES+1
          if (!empty) begin
            pop     = 1'b1;
            cnt_d   = '0;
            state_d = StSettle;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_select, bus.cmd_d0, bus.cmd_d1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      op_sel_q  <= '0;
      op_d0_q   <= '0;
      op_d1_q   <= '0;
      res_sel_q <= '0;
      res_q0_q  <= '0;
      res_q1_q  <= '0;
      done_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        op_sel_q <= head[10:8];
        op_d0_q  <= head[7:4];
        op_d1_q  <= head[3:0];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      if (capture) begin
        res_sel_q <= op_sel_q;
        res_q0_q  <= bus.mux_q_0;
        res_q1_q  <= (op_sel_q == 3'd1) ? bus.mux_q_1 : 4'd0;
      end
      if (handshake) begin
        done_q <= done_q + 8'd1;
      end
    end
  end

  assign bus.cmd_ready  = ready_q & ~full;
  assign bus.mux_select = op_sel_q;
  assign bus.mux_d0     = op_d0_q;
  assign bus.mux_d1     = op_d1_q;
  assign bus.res_valid  = (state_q == StResult);
  assign bus.res_select = res_sel_q;
  assign bus.res_q_0    = res_q0_q;
  assign bus.res_q_1    = res_q1_q;
  assign bus.busy       = (state_q != StIdle) | ~empty;
  assign bus.done_count = done_q;
endmodule

// File: tb/tb_mux_op_sequencer.sv
// Scoreboard bench for mux_op_sequencer: a SETTLE_CYCLES=1 instance and a SETTLE_CYCLES=3
// instance, each driven by a behavioural mux model and checked by a queue-popping monitor.
module tb_mux_op_sequencer;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] q0;
    logic [3:0] q1;
  } exp_t;

  exp_t       exp1[$];
  exp_t       exp3[$];
  int         hs1[$];
  logic [3:0] xr0 = 4'd0;
  logic [3:0] xr1 = 4'd0;

  mux_op_sequencer_if if1 ();
  mux_op_sequencer_if if3 ();

  mux_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  mux_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  function automatic logic [3:0] mq0(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0:             return a;
      3'd1:             return a + b;
      3'd2, 3'd3, 3'd4: return ~b;
      default:          return 4'd0;
    endcase
  endfunction

  // q_1 is deliberately nonzero for non-add selects so the sequencer's forcing is exercised
  function automatic logic [3:0] mq1(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    return (s == 3'd1) ? a - b : a ^ b ^ 4'h6;
  endfunction

  assign if1.mux_q_0 = mq0(if1.mux_select, if1.mux_d0, if1.mux_d1);
  assign if1.mux_q_1 = mq1(if1.mux_select, if1.mux_d0, if1.mux_d1);
  assign if3.mux_q_0 = mq0(if3.mux_select, if3.mux_d0, if3.mux_d1) ^ xr0;
  assign if3.mux_q_1 = mq1(if3.mux_select, if3.mux_d0, if3.mux_d1) ^ xr1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (if1.res_valid === 1'b1) begin
      if (exp1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_result: got res_select=%0h q0=%0h with none pending",
                 if1.res_select, if1.res_q_0);
      end else begin
        chk("dut1_res_select", if1.res_select, exp1[0].sel);
        chk("dut1_res_q_0", if1.res_q_0, exp1[0].q0);
        chk("dut1_res_q_1", if1.res_q_1, exp1[0].q1);
        if (if1.res_ready) begin
          void'(exp1.pop_front());
          hs1.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if3.res_valid === 1'b1) begin
      if (exp3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut3_unexpected_result: got res_select=%0h q0=%0h with none pending",
                 if3.res_select, if3.res_q_0);
      end else begin
        chk("dut3_res_select", if3.res_select, exp3[0].sel);
        chk("dut3_res_q_0", if3.res_q_0, exp3[0].q0);
        chk("dut3_res_q_1", if3.res_q_1, exp3[0].q1);
        if (if3.res_ready) void'(exp3.pop_front());
      end
    end
  end

  task automatic push1(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] e0, input logic [3:0] e1);
    int n = 0;
    if1.cmd_valid  = 1'b1;
    if1.cmd_select = s;
    if1.cmd_d0     = a;
    if1.cmd_d1     = b;
    @(negedge clk);
    while (!if1.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("dut1_push_accept", if1.cmd_ready, 1);
    if (if1.cmd_ready) exp1.push_back('{sel: s, q0: e0, q1: e1});
    @(posedge clk);
    #1 if1.cmd_valid = 1'b0;
  endtask

  task automatic push3(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] e0, input logic [3:0] e1);
    int n = 0;
    if3.cmd_valid  = 1'b1;
    if3.cmd_select = s;
    if3.cmd_d0     = a;
    if3.cmd_d1     = b;
    @(negedge clk);
    while (!if3.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("dut3_push_accept", if3.cmd_ready, 1);
    if (if3.cmd_ready) exp3.push_back('{sel: s, q0: e0, q1: e1});
    @(posedge clk);
    #1 if3.cmd_valid = 1'b0;
  endtask

  task automatic drain1(input int budget);
    int n = 0;
    while (exp1.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2 chk("dut1_drain_pending", exp1.size(), 0);
  endtask

  task automatic drain3(input int budget);
    int n = 0;
    while (exp3.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2 chk("dut3_drain_pending", exp3.size(), 0);
  endtask

  // {sel, d0, d1, q0, q1}, hand-computed mod 16
  int tv[8][5] = '{'{0, 1, 2, 1, 0}, '{1, 3, 4, 7, 15}, '{2, 5, 6, 9, 0}, '{3, 7, 8, 7, 0},
                   '{4, 9, 10, 5, 0}, '{5, 11, 12, 0, 0}, '{6, 13, 14, 0, 0}, '{7, 14, 15, 0, 0}};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    if1.cmd_valid = 1'b0; if1.cmd_select = '0; if1.cmd_d0 = '0; if1.cmd_d1 = '0;
    if1.res_ready = 1'b1;
    if3.cmd_valid = 1'b0; if3.cmd_select = '0; if3.cmd_d0 = '0; if3.cmd_d1 = '0;
    if3.res_ready = 1'b1;

    #2;
    chk("rst_cmd_ready", if1.cmd_ready, 0);
    chk("rst_res_valid", if1.res_valid, 0);
    chk("rst_res_q_0", if1.res_q_0, 0);
    chk("rst_mux_select", if1.mux_select, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_done_count", if1.done_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rel_cmd_ready_before_edge", if1.cmd_ready, 0);
    @(posedge clk);
    #1 chk("rel_cmd_ready_after_edge", if1.cmd_ready, 1);

    // Single op latency: push E0, pop E1, capture E2, handshake E3
    push1(3'd1, 4'd5, 4'd3, 4'd8, 4'd2);
    chk("t1_valid_e0", if1.res_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1 chk("t1_valid_window", if1.res_valid, (k == 2) ? 1 : 0);
    end
    chk("t1_done_count", if1.done_count, 1);

    push1(3'd1, 4'd2, 4'd5, 4'd7, 4'd13);
    push1(3'd3, 4'd6, 4'b1010, 4'b0101, 4'd0);
    push1(3'd7, 4'd9, 4'd4, 4'd0, 4'd0);
    drain1(50);
    chk("t2_done_count", if1.done_count, 4);

    // Backpressure: 4 queued + 1 in flight, sixth held
    if1.res_ready = 1'b0;
    push1(3'd0, 4'd3, 4'd9, 4'd3, 4'd0);
    push1(3'd1, 4'd15, 4'd1, 4'd0, 4'd14);
    push1(3'd2, 4'd0, 4'd0, 4'd15, 4'd0);
    push1(3'd4, 4'd7, 4'd12, 4'd3, 4'd0);
    push1(3'd5, 4'd8, 4'd8, 4'd0, 4'd0);
    chk("bp_cmd_ready_full", if1.cmd_ready, 0);
    fork
      push1(3'd1, 4'd9, 4'd9, 4'd2, 4'd0);
    join_none
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk("bp_stall_ready", if1.cmd_ready, 0);
      chk("bp_stall_valid", if1.res_valid, 1);
    end
    chk("bp_sixth_held", exp1.size(), 5);
    chk("bp_done_stalled", if1.done_count, 4);
    if1.res_ready = 1'b1;
    drain1(100);
    chk("bp_done_count", if1.done_count, 10);

    // Throughput from a fresh reset
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("tp_reset_done_count", if1.done_count, 0);
    @(posedge clk);
    #1 hs1.delete();
    for (int i = 0; i < 8; i++) begin
      push1(3'(tv[i][0]), 4'(tv[i][1]), 4'(tv[i][2]), 4'(tv[i][3]), 4'(tv[i][4]));
    end
    chk("tp_busy_during", if1.busy, 1);
    drain1(100);
    chk("tp_busy_after", if1.busy, 0);
    chk("tp_done_count", if1.done_count, 8);
    chk("tp_handshakes", hs1.size(), 8);
    for (int i = 1; i < hs1.size(); i++) chk("tp_gap", hs1[i] - hs1[i-1], 2);

    // SETTLE_CYCLES=3: inputs held 3 cycles, capture takes the cycle-3 mux value
    push3(3'd1, 4'd4, 4'd1, 4'd6, 4'd6);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1 chk("s3_mux_select", if3.mux_select, 1);
      chk("s3_mux_d0", if3.mux_d0, 4);
      chk("s3_mux_d1", if3.mux_d1, 1);
      chk("s3_valid_low", if3.res_valid, 0);
      if (k == 2) begin
        xr0 = 4'hf;
        xr1 = 4'hf;
      end else if (k == 3) begin
        xr0 = 4'h3;
        xr1 = 4'h5;
      end
    end
    @(posedge clk);
    #1 chk("s3_valid_high", if3.res_valid, 1);
    drain3(20);
    xr0 = 4'h0;
    xr1 = 4'h0;
    chk("s3_done_count", if3.done_count, 1);

    // Reset during SETTLE with two commands queued
    push3(3'd6, 4'd5, 4'd7, 4'd0, 4'd0);
    push3(3'd1, 4'd1, 4'd1, 4'd2, 4'd0);
    push3(3'd0, 4'd9, 4'd2, 4'd9, 4'd0);
    chk("mr_mux_select_before", if3.mux_select, 6);
    chk("mr_busy_before", if3.busy, 1);
    #2 reset = 1'b1;
    #1 chk("mr_mux_select", if3.mux_select, 0);
    chk("mr_mux_d0", if3.mux_d0, 0);
    chk("mr_mux_d1", if3.mux_d1, 0);
    chk("mr_res_valid", if3.res_valid, 0);
    chk("mr_cmd_ready", if3.cmd_ready, 0);
    chk("mr_busy", if3.busy, 0);
    chk("mr_done_count", if3.done_count, 0);
    exp3.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("mr_busy_after", if3.busy, 0);
    chk("mr_cmd_ready_after", if3.cmd_ready, 1);
    chk("mr_done_after", if3.done_count, 0);
    chk("mr_valid_after", if3.res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
